axi_line_burst_master: RTL and testbench
========================================

// Module: axi_line_burst_master
// PURPOSE
//  Bridges the core-side cache refill/writeback port onto the AXI4 master channels of axi_interface.
//  One request moves one cache line as a single INCR burst of C_M_AXI_BURST_LEN beats:
//  read (refill) via AR/R, write (writeback) via AW/W/B.
//  Sits between the L1 cache controller (upstream) and the AXI master modport (downstream).
//  One transaction is outstanding at a time.
// PARAMETERS
//  C_M_AXI_BURST_LEN   16  beats per line (power of 2, 2..256)
//  C_M_AXI_ID_WIDTH     1  AXI ID width; all IDs driven 0
//  C_M_AXI_ADDR_WIDTH  32  address width
//  C_M_AXI_DATA_WIDTH  32  beat width (power of 2, >=32); LINE_W = BURST_LEN*DATA_WIDTH
// PORTS
//  m_axi_aclk      in   1        single clock
//  m_axi_aresetn   in   1        reset, asynchronous, active-low
//  req_valid       in   1        line request valid
//  req_ready       out  1        request accepted when valid&ready
//  req_write       in   1        1=writeback, 0=refill
//  req_addr        in   ADDR_W   line address; offset bits ignored
//  req_wline       in   LINE_W   writeback data; beat k = bits [k*DW +: DW]
//  resp_valid      out  1        one-cycle completion pulse (no back-pressure)
//  resp_err        out  1        qualified by resp_valid: SLVERR/DECERR or bad RLAST
//  resp_rline      out  LINE_W   refill data; stable from resp_valid until next accept
//  m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,user,valid} out; m_axi_awready in
//  m_axi_w{data,strb,last,user,valid} out; m_axi_wready in
//  m_axi_b{id,resp,user,valid} in; m_axi_bready out
//  m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,user,valid} out; m_axi_arready in
//  m_axi_r{id,data,resp,last,user,valid} in; m_axi_rready out
// BEHAVIOUR
//  Reset: FSM=IDLE, beat counter=0.
//   All *valid, *ready, resp_valid, resp_err, wlast = 0; resp_rline = 0.
//  Reset mid-burst: abort immediately, no resp_valid; the slave is also reset by the bench.
//  Constants:
//   ax/wlen = BURST_LEN-1; size = log2(DW/8); burst = 2'b01 (INCR); wstrb = all ones.
//   id, lock, cache, prot, qos, user = 0.
//  Address = req_addr with low log2(LINE_W/8) bits forced 0; registered at accept.
//  req_write and req_wline are also registered at accept.
//  req_ready = (state==IDLE). Accept -> AR (read) or AW (write) next cycle.
//  FSM:
//   IDLE -> AR | AW
//   AR: arvalid=1 until arready -> R
//   R: rready=1; each rvalid stores rdata at beat[cnt], cnt++.
//    Beat with cnt==BURST_LEN-1 -> RESP.
//   AW: awvalid=1 until awready -> W
//   W: wvalid=1, wdata=beat[cnt], wlast=(cnt==BURST_LEN-1).
//    cnt++ on wready; last handshake -> B
//   B: bready=1; bvalid -> RESP
//   RESP: resp_valid=1 for exactly 1 cycle -> IDLE, cnt=0.
//  Error = any beat rresp[1] | bresp[1];
//   or rlast==1 with cnt!=BURST_LEN-1; or rlast==0 on the final beat.
//  Error is sticky for the transaction, cleared on accept.
//  Early rlast does not truncate: the counter still decides the end.
//  Once asserted, valid is never dropped and payload is never changed before its handshake (AXI rule).
//  Latency: accept -> arvalid 1 cycle; last R/B handshake -> resp_valid 1 cycle.
//  cnt width is log2(BURST_LEN)+1. It is compared, never wraps inside a burst.
//  Ignored inputs: r/b id and user.
// TESTING
//  1. Refill 0x1000_0047:
//     araddr=0x1000_0040, arlen=15, arsize=2, arburst=1.
//     16 beats 0xA0..0xAF, rlast on beat 15 -> resp_valid 1 cycle, err=0.
//     resp_rline[31:0]=0xA0, [511:480]=0xAF.
//  2. Writeback 0x2000_0000, line beats 0..15 = 0x100+k:
//     AW then 16 W beats, wlast only on beat 15, then bresp=OKAY -> resp_err=0.
//  3. Back-pressure: arready/awready delayed 5 cycles, wready/rvalid toggling 1/0.
//     -> valid and payload held stable; data correct; each beat counted once.
//  4. Errors: rresp=SLVERR on beat 3 -> full 16 beats consumed, resp_err=1.
//     bresp=DECERR -> resp_err=1.
//     rlast on beat 7 -> resp_err=1.
//  5. Reset asserted at W beat 6 -> next edge all valids=0, req_ready=1.
//     Release, refill succeeds.
//  6. req_valid held high through 3 back-to-back refills -> exactly 3 AR handshakes.
//     req_ready=0 while busy.

Source files
------------

// File: rtl/axi_line_burst_master.sv
// Cache-line burst master: moves one cache line per request as a single
// INCR burst (refill over AR/R, writeback over AW/W/B), one transaction at a time.
module axi_line_burst_master #(
   parameter int C_M_AXI_BURST_LEN  = 16,
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                                              m_axi_aclk,
   input  logic                                              m_axi_aresetn,
   // core-side line port
   input  logic                                              req_valid,
   output logic                                              req_ready,
   input  logic                                              req_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]                     req_addr,
   input  logic [C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH-1:0]   req_wline,
   output logic                                              resp_valid,
   output logic                                              resp_err,
   output logic [C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH-1:0]   resp_rline,
   // write address channel
   output logic [C_M_AXI_ID_WIDTH-1:0]                       m_axi_awid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]                     m_axi_awaddr,
   output logic [7:0]                                        m_axi_awlen,
   output logic [2:0]                                        m_axi_awsize,
   output logic [1:0]                                        m_axi_awburst,
   output logic                                              m_axi_awlock,
   output logic [3:0]                                        m_axi_awcache,
   output logic [2:0]                                        m_axi_awprot,
   output logic [3:0]                                        m_axi_awqos,
   output logic                                              m_axi_awuser,
   output logic                                              m_axi_awvalid,
   input  logic                                              m_axi_awready,
   // write data channel
   output logic [C_M_AXI_DATA_WIDTH-1:0]                     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]                   m_axi_wstrb,
   output logic                                              m_axi_wlast,
   output logic                                              m_axi_wuser,
   output logic                                              m_axi_wvalid,
   input  logic                                              m_axi_wready,
   // write response channel
   input  logic [C_M_AXI_ID_WIDTH-1:0]                       m_axi_bid,
   input  logic [1:0]                                        m_axi_bresp,
   input  logic                                              m_axi_buser,
   input  logic                                              m_axi_bvalid,
   output logic                                              m_axi_bready,
   // read address channel
   output logic [C_M_AXI_ID_WIDTH-1:0]                       m_axi_arid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]                     m_axi_araddr,
   output logic [7:0]                                        m_axi_arlen,
   output logic [2:0]                                        m_axi_arsize,
   output logic [1:0]                                        m_axi_arburst,
   output logic                                              m_axi_arlock,
   output logic [3:0]                                        m_axi_arcache,
   output logic [2:0]                                        m_axi_arprot,
   output logic [3:0]                                        m_axi_arqos,
   output logic                                              m_axi_aruser,
   output logic                                              m_axi_arvalid,
   input  logic                                              m_axi_arready,
   // read data channel
   input  logic [C_M_AXI_ID_WIDTH-1:0]                       m_axi_rid,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]                     m_axi_rdata,
   input  logic [1:0]                                        m_axi_rresp,
   input  logic                                              m_axi_rlast,
   input  logic                                              m_axi_ruser,
   input  logic                                              m_axi_rvalid,
   output logic                                              m_axi_rready
);

   localparam int BL     = C_M_AXI_BURST_LEN;
   localparam int DW     = C_M_AXI_DATA_WIDTH;
   localparam int AW     = C_M_AXI_ADDR_WIDTH;
   localparam int LINE_W = BL * DW;
   localparam int IDX_W  = $clog2(BL);
   localparam int CNT_W  = IDX_W + 1;
   localparam int OFF_W  = $clog2(LINE_W / 8);

   localparam logic [7:0]       AXLEN    = 8'(BL - 1);
   localparam logic [2:0]       AXSIZE   = 3'($clog2(DW / 8));
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BL - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [AW-1:0]       addr_q;
   logic [LINE_W-1:0]   wline_q;
   logic [LINE_W-1:0]   rline_q;

   logic                accept;
   logic                last_beat;
   logic                rd_beat;
   logic [IDX_W-1:0]    beat_idx;
   logic [DW-1:0]       wbeat [BL];

   assign accept    = (state_q == S_IDLE) && req_valid;
   assign last_beat = (cnt_q == LAST_CNT);
   assign rd_beat   = (state_q == S_R) && m_axi_rvalid;
   assign beat_idx  = cnt_q[IDX_W-1:0];

   // Beat view of the registered writeback line, so wdata is a plain array select.
   genvar gi;
   generate
      for (gi = 0; gi < BL; gi++) begin : g_wbeat
         assign wbeat[gi] = wline_q[gi*DW +: DW];
      end
   endgenerate

   // State, beat counter and sticky error register.
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: the counter alone decides where a burst ends; an early or
   // missing RLAST only marks the transaction as failed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = req_write ? S_AW : S_AR;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_AR: if (m_axi_arready) state_d = S_R;
         S_R: begin
            if (m_axi_rvalid) begin
               cnt_d = cnt_q + CNT_W'(1);
               err_d = err_q | m_axi_rresp[1] | (m_axi_rlast != last_beat);
               if (last_beat) state_d = S_RESP;
            end
         end
         S_AW: if (m_axi_awready) state_d = S_W;
         S_W: begin
            if (m_axi_wready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last_beat) state_d = S_B;
            end
         end
         S_B: begin
            if (m_axi_bvalid) begin
               err_d   = err_q | m_axi_bresp[1];
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request payload capture at accept and refill beat storage.
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= {req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
            wline_q <= req_wline;
         end
         if (rd_beat) begin
            for (int i = 0; i < BL; i++) begin
               if (beat_idx == IDX_W'(i)) rline_q[i*DW +: DW] <= m_axi_rdata;
            end
         end
      end
   end

   // Handshake outputs decode straight from the state, so valids cannot drop early.
   assign req_ready     = (state_q == S_IDLE);
   assign m_axi_arvalid = (state_q == S_AR);
   assign m_axi_rready  = (state_q == S_R);
   assign m_axi_awvalid = (state_q == S_AW);
   assign m_axi_wvalid  = (state_q == S_W);
   assign m_axi_wlast   = (state_q == S_W) && last_beat;
   assign m_axi_bready  = (state_q == S_B);
   assign resp_valid    = (state_q == S_RESP);
   assign resp_err      = (state_q == S_RESP) && err_q;
   assign resp_rline    = rline_q;

   assign m_axi_wdata   = wbeat[beat_idx];
   assign m_axi_wstrb   = '1;
   assign m_axi_wuser   = 1'b0;

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = AXLEN;
   assign m_axi_awsize  = AXSIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_awuser  = 1'b0;

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = AXLEN;
   assign m_axi_arsize  = AXSIZE;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd0;
   assign m_axi_arprot  = 3'd0;
   assign m_axi_arqos   = 4'd0;
   assign m_axi_aruser  = 1'b0;

   // IDs, user bits, EXOKAY bits and line-offset address bits carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{m_axi_bid, m_axi_buser, m_axi_bresp[0], m_axi_rid,
                            m_axi_ruser, m_axi_rresp[0], req_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_axi_line_burst_master.sv
// Self-checking bench: acts as AXI slave with randomized timing and compares
// every transaction against a line-level model of what the master must do.
module tb_axi_line_burst_master;

   localparam int BL = 16;
   localparam int DW = 32;
   localparam int LW = BL * DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [LW-1:0] req_wline, resp_rline;
   logic resp_valid, resp_err;
   logic [0:0] awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize, awprot, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awlock, arlock, awuser, aruser, wuser, buser, ruser;
   logic [3:0] awcache, arcache, awqos, arqos, wstrb;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;

   int n_checks = 0;
   int n_errors = 0;
   int ar_hs = 0;
   int txn_no = 0;
   bit busy = 1'b0;

   logic [31:0] got_araddr, got_awaddr, first_wdata, last_wdata;
   logic [LW-1:0] got_rline;
   logic got_err;
   int wlast_hs;

   always #5 clk = ~clk;

   axi_line_burst_master dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wline(req_wline),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rline(resp_rline),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awuser(awuser),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wuser(wuser),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_buser(buser), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_aruser(aruser),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_ruser(ruser), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_slave();
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rlast = 0; rdata = 0;
      bid = 0; rid = 0; buser = 0; ruser = 0;
   endtask

   // Per-cycle protocol monitor, sampled 1 time unit after the active edge.
   logic p_arvalid, p_awvalid, p_wvalid, p_wlast, p_req_ready, p_resp_valid;
   logic [31:0] p_araddr, p_awaddr, p_wdata;
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         busy = 0;
         p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_wlast = 0;
         p_req_ready = 1; p_resp_valid = 0;
         p_araddr = 0; p_awaddr = 0; p_wdata = 0;
      end else begin
         if (p_arvalid && !arready) begin
            chk("ar_hold", arvalid, 1);
            chk("araddr_hold", araddr, p_araddr);
         end
         if (p_awvalid && !awready) begin
            chk("aw_hold", awvalid, 1);
            chk("awaddr_hold", awaddr, p_awaddr);
         end
         if (p_wvalid && !wready) begin
            chk("w_hold", wvalid, 1);
            chk("wdata_hold", wdata, p_wdata);
            chk("wlast_hold", wlast, p_wlast);
         end
         if (p_arvalid && arready) ar_hs++;
         if (p_req_ready && req_valid) busy = 1;
         if (p_resp_valid) busy = 0;
         chk("req_ready", req_ready, !busy);
         if (arvalid) begin
            chk("arlen", arlen, 8'd15);
            chk("arsize", arsize, 3'd2);
            chk("arburst", arburst, 2'b01);
            chk("ar_zero", {arid, arlock, arcache, arprot, arqos, aruser}, 0);
         end
         if (awvalid) begin
            chk("awlen", awlen, 8'd15);
            chk("awsize", awsize, 3'd2);
            chk("awburst", awburst, 2'b01);
            chk("aw_zero", {awid, awlock, awcache, awprot, awqos, awuser}, 0);
         end
         if (wvalid) chk("wstrb_user", {wstrb, wuser}, {4'hF, 1'b0});
         p_arvalid = arvalid; p_awvalid = awvalid; p_wvalid = wvalid; p_wlast = wlast;
         p_req_ready = req_ready; p_resp_valid = resp_valid;
         p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata;
      end
   end

   // One full line transaction. Called and returns on a falling edge.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input bit rnd,
                          input logic [31:0] base, input int err_beat, input int rlast_beat,
                          input bit berr, input bit bp, input bit hold_valid,
                          input int abort_beat);
      logic [31:0] beats [BL];
      logic [LW-1:0] line;
      bit exp_err;
      int k, d, delay;
      for (int i = 0; i < BL; i++) begin
         beats[i] = rnd ? $urandom : base + 32'(i);
         line[i*DW +: DW] = beats[i];
      end
      exp_err = wr ? berr : ((err_beat >= 0 && err_beat < BL) || rlast_beat != BL - 1);
      txn_no++;
      req_write = wr; req_addr = addr; req_valid = 1;
      req_wline = wr ? line : {16{$urandom}};
      d = 0;
      while (!req_ready && d < 200) begin @(negedge clk); d++; end
      if (!req_ready) begin chk("accept_timeout", req_ready, 1); req_valid = 0; return; end
      @(negedge clk);
      if (!hold_valid) req_valid = 0;
      chk("addr_latency", wr ? awvalid : arvalid, 1);
      delay = bp ? 5 : $urandom_range(0, 3);
      d = 0;
      while (1) begin
         if (wr) awready = (d >= delay); else arready = (d >= delay);
         if (wr ? (awvalid && awready) : (arvalid && arready)) break;
         if (d > 50) begin chk("addr_timeout", wr ? awvalid : arvalid, 1); return; end
         @(negedge clk); d++;
      end
      if (wr) begin
         got_awaddr = awaddr;
         chk("awaddr", awaddr, addr & ~32'h3F);
      end else begin
         got_araddr = araddr;
         chk("araddr", araddr, addr & ~32'h3F);
      end
      @(negedge clk);
      awready = 0; arready = 0;
      k = 0; d = 0;
      if (!wr) begin
         while (k < BL) begin
            rvalid = bp ? (d % 2 == 0) : 1'($urandom_range(0, 1));
            rdata = rvalid ? beats[k] : $urandom;
            rresp = (rvalid && k == err_beat) ? 2'b10 : 2'($urandom_range(0, 1));
            rlast = rvalid && (k == rlast_beat);
            if (rvalid && rready) k++;
            if (d > 400) begin chk("r_timeout", k, BL); clear_slave(); return; end
            @(negedge clk); d++;
         end
         rvalid = 0; rlast = 0; rresp = 0;
      end else begin
         wlast_hs = 0;
         while (k < BL) begin
            if (k == abort_beat) begin
               rst_n = 0; req_valid = 0; clear_slave();
               @(posedge clk); #1;
               chk("abort_valids", {awvalid, wvalid, arvalid, rready, bready, resp_valid}, 0);
               chk("abort_req_ready", req_ready, 1);
               @(negedge clk);
               rst_n = 1;
               $display("txn %0d write addr=%h aborted by reset at beat %0d", txn_no, addr, k);
               return;
            end
            if (wvalid) begin
               chk("wdata", wdata, beats[k]);
               chk("wlast", wlast, k == BL - 1);
               if (k == 0) first_wdata = wdata;
               last_wdata = wdata;
            end
            wready = bp ? (d % 2 == 1) : 1'($urandom_range(0, 1));
            if (wvalid && wready) begin
               if (wlast) wlast_hs++;
               k++;
            end
            if (d > 400) begin chk("w_timeout", k, BL); clear_slave(); return; end
            @(negedge clk); d++;
         end
         wready = 0;
         delay = $urandom_range(0, 3);
         d = 0;
         while (1) begin
            bvalid = (d >= delay);
            bresp = berr ? 2'b11 : 2'($urandom_range(0, 1));
            if (bvalid && bready) break;
            if (d > 50) begin chk("b_timeout", bready, 1); clear_slave(); return; end
            @(negedge clk); d++;
         end
         @(negedge clk);
         bvalid = 0; bresp = 0;
      end
      chk("resp_valid", resp_valid, 1);
      chk("resp_err", resp_err, exp_err);
      if (!wr) chk("resp_rline", resp_rline, line);
      got_rline = resp_rline;
      got_err = resp_err;
      $display("txn %0d %s addr=%h bp=%0b err=%0b exp_err=%0b", txn_no,
               wr ? "write" : "read", addr, bp, resp_err, exp_err);
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
   endtask

   initial begin
      int base_hs;
      req_valid = 0; req_write = 0; req_addr = 0; req_wline = 0;
      clear_slave();
      repeat (3) @(negedge clk);
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wlast}, 0);
      chk("rst_resp", {resp_valid, resp_err}, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rline", resp_rline, 0);
      rst_n = 1;
      @(negedge clk);

      // Refill with offset bits set
      run_txn(0, 32'h1000_0047, 0, 32'hA0, -1, 15, 0, 0, 0, -1);
      chk("t1_araddr", got_araddr, 32'h1000_0040);
      chk("t1_beat0", got_rline[31:0], 32'hA0);
      chk("t1_beat15", got_rline[511:480], 32'hAF);
      chk("t1_err", got_err, 0);

      // Writeback with beat k = 0x100+k
      run_txn(1, 32'h2000_0000, 0, 32'h100, -1, 15, 0, 0, 0, -1);
      chk("t2_awaddr", got_awaddr, 32'h2000_0000);
      chk("t2_first", first_wdata, 32'h100);
      chk("t2_last", last_wdata, 32'h10F);
      chk("t2_wlast_count", wlast_hs, 1);
      chk("t2_err", got_err, 0);

      // Back-pressure
      run_txn(0, 32'h3000_0080, 1, 0, -1, 15, 0, 1, 0, -1);
      run_txn(1, 32'h3000_00C0, 1, 0, -1, 15, 0, 1, 0, -1);

      // Error cases
      run_txn(0, 32'h4000_0000, 0, 32'h500, 3, 15, 0, 0, 0, -1);
      chk("t4_slverr", got_err, 1);
      run_txn(1, 32'h4000_0040, 0, 32'h600, -1, 15, 1, 0, 0, -1);
      chk("t4_decerr", got_err, 1);
      run_txn(0, 32'h4000_0080, 0, 32'h700, -1, 7, 0, 0, 0, -1);
      chk("t4_early_rlast", got_err, 1);
      run_txn(0, 32'h4000_00C0, 0, 32'h800, -1, 15, 0, 0, 0, -1);
      chk("t4_err_cleared", got_err, 0);

      // Reset during W beat 6, then a clean refill
      run_txn(1, 32'h5000_0000, 1, 0, -1, 15, 0, 0, 0, 6);
      run_txn(0, 32'h5000_0040, 0, 32'hC0, -1, 15, 0, 0, 0, -1);
      chk("t5_err", got_err, 0);

      // Back-to-back refills with req_valid held high
      base_hs = ar_hs;
      for (int i = 0; i < 3; i++)
         run_txn(0, 32'h6000_0000 + 32'(i * 64), 1, 0, -1, 15, 0, 0, 1, -1);
      req_valid = 0;
      repeat (3) @(negedge clk);
      chk("t6_ar_handshakes", ar_hs - base_hs, 3);

      // Randomized mix
      for (int i = 0; i < 24; i++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom, 1, 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 15,
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0, -1);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
